// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode and datapath control encodings for the MC_CPU
package mc_pkg;
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH     = 4'd0;
  localparam state_t S_DECODE    = 4'd1;
  localparam state_t S_MEM_ADDR  = 4'd2;
  localparam state_t S_MEM_READ  = 4'd3;
  localparam state_t S_MEM_WB    = 4'd4;
  localparam state_t S_MEM_WRITE = 4'd5;
  localparam state_t S_EXECUTE   = 4'd6;
  localparam state_t S_ALU_WB    = 4'd7;
  localparam state_t S_ADDI_EX   = 4'd8;
  localparam state_t S_ADDI_WB   = 4'd9;
  localparam state_t S_BRANCH    = 4'd10;
  localparam state_t S_JUMP      = 4'd11;
  localparam state_t S_HALT      = 4'd12;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  // first state after DECODE for a given opcode; unknown opcodes halt the core
  function automatic state_t dispatch(input logic [5:0] op);
    return op == OP_HALT ? S_HALT :
           op == OP_R ? S_EXECUTE :
           (op == OP_LW || op == OP_SW) ? S_MEM_ADDR :
           op == OP_ADDI ? S_ADDI_EX :
           op == OP_BEQ ? S_BRANCH :
           op == OP_J ? S_JUMP : S_HALT;
  endfunction
endpackage

// File: rtl/mc_counter.sv
// mc_counter: wrap-around event counter with synchronous reset
module mc_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);
  // count enabled cycles modulo 2^W
  always_ff @(posedge clk) count <= rst ? '0 : count + W'(en);
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MC_CPU controller with memory handshake, halt and perf counters
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);
  state_t state, next, dec_state;
  logic [31:0] wait_cnt;
  logic waiting, timeout, unused_funct;
  assign unused_funct = ^funct;
  assign waiting = (state == S_FETCH || state == S_MEM_READ || state == S_MEM_WRITE) && !mem_ready;
  assign timeout = MEM_TIMEOUT != 0 && waiting && wait_cnt == 32'(MEM_TIMEOUT - 1);
  assign dec_state = reset ? S_FETCH : state;
  // next-state sequencing; a memory timeout overrides everything
  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:     next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    next = dispatch(opcode);
      S_MEM_ADDR:  next = opcode == OP_LW ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   next = S_ALU_WB;
      S_ADDI_EX:   next = S_ADDI_WB;
      S_HALT:      next = S_HALT;
      default:     next = S_FETCH;
    endcase
    if (timeout) next = S_HALT;
  end
  // control decode; reset shows FETCH selects with every request/enable dropped
  always_comb begin
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 1'b0;
    pc_source = PCSRC_ALU;
    alu_op = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RT;
    reg_write = 1'b0;
    reg_dst = 1'b0;
    halted = 1'b0;
    case (dec_state)
      S_FETCH: begin
        mem_read = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write = mem_ready;
        ir_write = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d = 1'b1;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op = ALU_FUNCT;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
      end
      S_ADDI_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
    if (reset) begin
      pc_write = 1'b0;
      pc_write_cond = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      ir_write = 1'b0;
      reg_write = 1'b0;
    end
  end
  // state register and consecutive memory-wait counter
  always_ff @(posedge clk) begin
    state <= reset ? S_FETCH : next;
    wait_cnt <= (reset || !waiting) ? '0 : wait_cnt + 32'd1;
  end
  mc_counter #(.W(CNT_W)) u_cycles (.clk(clk), .rst(reset), .en(state != S_HALT), .count(cycle_count));
  mc_counter #(.W(CNT_W)) u_instrs (.clk(clk), .rst(reset), .en(state == S_DECODE), .count(instr_count));
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: instruction-level reference model checked every cycle against two controller instances
module tb_mc_control_fsm;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] J = 6'b000010, ADDI = 6'b001000, HLT = 6'b111111;
  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_ADDI = 3, K_BEQ = 4, K_J = 5;
  localparam int LEN [6] = '{4, 5, 4, 4, 3, 3};
  localparam int TO [2] = '{0, 4};
  logic clk = 0, reset = 1, mem_ready = 1;
  logic [5:0] opcode = 0, funct = 0;
  logic pw [2], pwc [2], iod [2], mr [2], mw [2], irw [2], m2r [2], asa [2], rw [2], rd [2], hl [2];
  logic [1:0] pcs [2], aop [2], asb [2];
  logic [31:0] cc [2], ic [2];
  int vectors = 0, miscompares = 0;
  bit chk_on = 0;
  int m_k [2], m_s [2], m_w [2];
  bit m_h [2];
  logic [31:0] m_c [2], m_i [2];
  always #5 clk = ~clk;
  mc_control_fsm #(.CNT_W(32), .MEM_TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pw[0]), .pc_write_cond(pwc[0]), .i_or_d(iod[0]), .mem_read(mr[0]), .mem_write(mw[0]),
    .ir_write(irw[0]), .mem_to_reg(m2r[0]), .pc_source(pcs[0]), .alu_op(aop[0]), .alu_src_a(asa[0]),
    .alu_src_b(asb[0]), .reg_write(rw[0]), .reg_dst(rd[0]), .halted(hl[0]),
    .cycle_count(cc[0]), .instr_count(ic[0]));
  mc_control_fsm #(.CNT_W(32), .MEM_TIMEOUT(4)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pw[1]), .pc_write_cond(pwc[1]), .i_or_d(iod[1]), .mem_read(mr[1]), .mem_write(mw[1]),
    .ir_write(irw[1]), .mem_to_reg(m2r[1]), .pc_source(pcs[1]), .alu_op(aop[1]), .alu_src_a(asa[1]),
    .alu_src_b(asb[1]), .reg_write(rw[1]), .reg_dst(rd[1]), .halted(hl[1]),
    .cycle_count(cc[1]), .instr_count(ic[1]));
  function automatic int kind_of(input logic [5:0] op);
    return op == R ? K_R : op == LW ? K_LW : op == SW ? K_SW : op == ADDI ? K_ADDI :
           op == BEQ ? K_BEQ : op == J ? K_J : -1;
  endfunction
  function automatic logic [16:0] got(input int i);
    return {pw[i], pwc[i], iod[i], mr[i], mw[i], irw[i], m2r[i], pcs[i], aop[i], asa[i], asb[i], rw[i], rd[i], hl[i]};
  endfunction
  // expected control word from instruction kind and step within that instruction
  function automatic logic [16:0] exp_ctl(input int i);
    logic p, pc, io, rq, wq, ir, mt, sa, wr, dr, h;
    logic [1:0] ps, ao, sb;
    int k, s;
    {p, pc, io, rq, wq, ir, mt, sa, wr, dr, h, ps, ao, sb} = '0;
    k = m_k[i];
    s = m_s[i];
    if (reset || (!m_h[i] && s == 0)) begin
      sb = 1; rq = !reset; p = mem_ready && !reset; ir = p;
    end else if (m_h[i]) h = 1;
    else if (s == 1) sb = 3;
    else if (s == 2 && (k == K_LW || k == K_SW || k == K_ADDI)) begin sa = 1; sb = 2; end
    else if (s == 2 && k == K_R) begin sa = 1; ao = 2; end
    else if (s == 2 && k == K_BEQ) begin sa = 1; ao = 1; pc = 1; ps = 1; end
    else if (s == 2 && k == K_J) begin p = 1; ps = 2; end
    else if (s == 3 && k == K_LW) begin rq = 1; io = 1; end
    else if (s == 3 && k == K_SW) begin wq = 1; io = 1; end
    else if (s == 3 && (k == K_R || k == K_ADDI)) begin wr = 1; dr = (k == K_R); end
    else if (s == 4 && k == K_LW) begin wr = 1; mt = 1; end
    return {p, pc, io, rq, wq, ir, mt, ps, ao, sa, sb, wr, dr, h};
  endfunction
  task automatic cmp(input string name, input logic [31:0] g, input logic [31:0] e);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, g, e, $time);
    end
  endtask
  // model advances on each rising edge from the inputs presented in that cycle
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit wt;
      if (reset) begin
        m_s[i] = 0; m_h[i] = 0; m_w[i] = 0; m_c[i] = 0; m_i[i] = 0;
      end else if (!m_h[i]) begin
        m_c[i] = m_c[i] + 1;
        wt = (m_s[i] == 0 || ((m_k[i] == K_LW || m_k[i] == K_SW) && m_s[i] == 3)) && !mem_ready;
        m_w[i] = wt ? m_w[i] + 1 : 0;
        if (m_s[i] == 0) begin
          if (mem_ready) m_s[i] = 1;
        end else if (m_s[i] == 1) begin
          m_i[i] = m_i[i] + 1;
          m_k[i] = kind_of(opcode);
          if (m_k[i] < 0) m_h[i] = 1;
          else m_s[i] = 2;
        end else if (!wt) m_s[i] = (m_s[i] == LEN[m_k[i]] - 1) ? 0 : m_s[i] + 1;
        if (TO[i] > 0 && m_w[i] == TO[i]) m_h[i] = 1;
      end
    end
  end
  // every cycle, both instances against the model
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        cmp($sformatf("ctl%0d", i), 32'(got(i)), 32'(exp_ctl(i)));
        cmp($sformatf("cycle_count%0d", i), cc[i], m_c[i]);
        cmp($sformatf("instr_count%0d", i), ic[i], m_i[i]);
      end
    end
  end
  task automatic go(input bit r, input logic [5:0] op, input bit rdy);
    @(posedge clk);
    #1;
    reset = r;
    opcode = op;
    mem_ready = rdy;
    funct = 6'($urandom);
    @(negedge clk);
  endtask
  // starting in a FETCH cycle, run one instruction until the next FETCH
  task automatic run_instr(input logic [5:0] op, output int n, output int nmw, output int npwc, output int npw);
    n = 1; nmw = 0; npwc = 0; npw = 0;
    repeat (20) begin
      go(0, op, 1);
      if (irw[0]) break;
      n++;
      nmw += int'(mw[0]);
      npwc += int'(pwc[0]);
      npw += int'(pw[0]);
    end
  endtask
  function automatic logic [5:0] pick();
    logic [5:0] ops [7] = '{R, LW, SW, BEQ, J, ADDI, HLT};
    int x = $urandom_range(19);
    return x < 18 ? ops[x % 6] : x == 18 ? HLT : 6'($urandom);
  endfunction
  initial begin
    int n, a, b, c;
    logic [31:0] frozen;
    @(posedge clk);
    chk_on = 1;
    go(1, R, 1);
    cmp("reset_mem_read", 32'(mr[0]), 0);
    cmp("reset_pc_write", 32'(pw[0]), 0);
    cmp("reset_alu_src_b", 32'(asb[0]), 1);
    go(0, R, 1);
    cmp("r_fetch_ir_write", 32'(irw[0]), 1);
    go(0, R, 1);
    cmp("r_decode_src_b", 32'(asb[0]), 3);
    go(0, R, 1);
    cmp("r_instr_count", ic[0], 1);
    cmp("r_exec_alu_op", 32'(aop[0]), 2);
    go(0, R, 1);
    cmp("r_wb", 32'({rw[0], rd[0]}), 3);
    go(0, LW, 1);
    cmp("lw_fetch", 32'(mr[0]), 1);
    go(0, LW, 1);
    go(0, LW, 1);
    go(0, LW, 0);
    go(0, LW, 0);
    cmp("lw_hold", 32'({mr[0], iod[0], rw[0]}), 6);
    go(0, LW, 1);
    go(0, LW, 1);
    cmp("lw_wb", 32'({rw[0], m2r[0], rd[0]}), 6);
    go(0, SW, 1);
    run_instr(SW, n, a, b, c);
    cmp("sw_cycles", n, 4);
    cmp("sw_pulses", {a[7:0], b[7:0], c[7:0]}, 32'h010000);
    run_instr(BEQ, n, a, b, c);
    cmp("beq_cycles", n, 3);
    cmp("beq_pulses", {a[7:0], b[7:0], c[7:0]}, 32'h000100);
    run_instr(J, n, a, b, c);
    cmp("j_cycles", n, 3);
    cmp("j_pulses", {a[7:0], b[7:0], c[7:0]}, 32'h000001);
    go(0, HLT, 1);
    go(0, HLT, 1);
    cmp("halt_op", 32'(hl[0]), 1);
    frozen = cc[0];
    repeat (3) go(0, HLT, 1);
    cmp("halt_frozen", cc[0], frozen);
    go(1, 6'b010101, 1);
    go(0, 6'b010101, 1);
    cmp("post_reset_counts", {cc[0][15:0], ic[0][15:0]}, 0);
    go(0, 6'b010101, 1);
    go(0, 6'b010101, 1);
    cmp("illegal_halt", 32'(hl[0]), 1);
    go(1, SW, 1);
    go(0, SW, 1);
    go(0, SW, 1);
    go(0, SW, 1);
    go(0, SW, 0);
    cmp("sw_wait", 32'(mw[0]), 1);
    go(1, SW, 0);
    cmp("sw_reset_drop", 32'(mw[0]), 0);
    go(0, SW, 0);
    cmp("sw_reset_fetch", 32'({mr[0], mw[0]}), 2);
    go(1, R, 0);
    for (int k = 0; k < 4; k++) begin
      go(0, R, 0);
      cmp("to_wait", 32'({hl[1], irw[1]}), 0);
    end
    go(0, R, 0);
    cmp("to_halt", 32'({hl[1], hl[0]}), 2);
    go(1, R, 1);
    repeat (4000) begin
      logic [5:0] op;
      bit r;
      op = opcode;
      if ((m_h[0] || m_s[0] == 0) && (m_h[1] || m_s[1] == 0)) op = pick();
      r = ($urandom_range(99) == 0) || (m_h[0] && m_h[1] && $urandom_range(3) == 0);
      go(r, op, $urandom_range(3) != 0);
    end
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
